// File: rtl/interboard_rx_pkg.sv
// Shared definitions for the board-to-board link: message codes, frame geometry,
// bit positions and receiver state encodings.
package interboard_rx_pkg;

    localparam int FRAME_BEATS = 4;
    localparam int BEAT_W      = 6;
    localparam int FRAME_W     = FRAME_BEATS * BEAT_W;

    localparam logic [3:0] MSG_TABLE_TAKE      = 4'd0;
    localparam logic [3:0] MSG_TABLE_DOWN      = 4'd1;
    localparam logic [3:0] MSG_TABLE_SHIFT     = 4'd2;
    localparam logic [3:0] MSG_HAND_TAKE       = 4'd3;
    localparam logic [3:0] MSG_HAND_DOWN       = 4'd4;
    localparam logic [3:0] MSG_STATE_TURN      = 4'd5;
    localparam logic [3:0] MSG_STATE_SCORE     = 4'd6;
    localparam logic [3:0] MSG_STATE_RST_TABLE = 4'd7;
    localparam logic [3:0] MSG_RST             = 4'hF;

    localparam int MARK_BIT   = 0;
    localparam int PAR_BIT    = 1;
    localparam int FIELDS_LO  = 2;
    localparam int FIELDS_HI  = 23;

    typedef enum logic [1:0] {
        S_WAIT_REQ = 2'd0,
        S_WAIT_REL = 2'd1,
        S_DECODE   = 2'd2
    } rx_state_t;

    // Field order matches frame bits [23:2], MSB first.
    typedef struct packed {
        logic [3:0] msg_type;
        logic       move_dir;
        logic [2:0] sel_len;
        logic [4:0] block_x;
        logic [2:0] block_y;
        logic [5:0] card;
    } ib_fields_t;

    function automatic logic frame_ok(input logic [FRAME_W-1:0] f);
        return f[MARK_BIT] && !(^f[FIELDS_HI:PAR_BIT]);
    endfunction

endpackage

// File: rtl/interboard_rx_if.sv
// Peer handshake bundle: req/data from the transmitter, ack back from the receiver.
interface interboard_rx_if;
    import interboard_rx_pkg::*;

    logic              ib_req;
    logic [BEAT_W-1:0] ib_data;
    logic              ib_ack;

    modport master (output ib_req, output ib_data, input ib_ack);
    modport slave  (input ib_req, input ib_data, output ib_ack);

endinterface

// File: rtl/interboard_rx_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous control bit.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/interboard_rx.sv
// Receive end of the board-to-board link: 4-beat req/ack deserialiser, frame check,
// command decode, mid-frame timeout and stale-request drain.
module interboard_rx
    import interboard_rx_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    interboard_rx_if.slave    ib,
    output logic              interboard_en,
    output logic              interboard_move_dir,
    output logic [3:0]        interboard_msg_type,
    output logic [4:0]        interboard_block_x,
    output logic [2:0]        interboard_block_y,
    output logic [5:0]        interboard_card,
    output logic [2:0]        interboard_sel_len,
    output logic              interboard_rst,
    output logic              frame_err,
    output logic              busy
);

    localparam int            TW     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT_CYC - 1);

    logic               req_s;
    rx_state_t          state;
    logic [1:0]         beat;
    logic [FRAME_W-1:0] sh;
    logic [TW-1:0]      tcnt;
    logic               drain;
    logic               ack;
    logic               counting;
    logic               timeout;
    ib_fields_t         fr;

    sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ib.ib_req),
        .q     (req_s)
    );

    assign fr       = sh[FIELDS_HI:FIELDS_LO];
    assign counting = (state == S_WAIT_REL) || ((state == S_WAIT_REQ) && (beat != 2'd0));
    assign timeout  = counting && (tcnt == TLIMIT);
    assign busy     = (beat != 2'd0) || (state != S_WAIT_REQ);
    assign ib.ib_ack = ack;

    // Handshake FSM; a timeout overrides any state and drops back to idle with an
    // error strobe. If the peer is still holding req, drain blocks re-capture of that beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= S_WAIT_REQ;
            beat                <= 2'd0;
            sh                  <= '0;
            tcnt                <= '0;
            drain               <= 1'b0;
            ack                 <= 1'b0;
            interboard_en       <= 1'b0;
            interboard_rst      <= 1'b0;
            frame_err           <= 1'b0;
            interboard_move_dir <= 1'b0;
            interboard_msg_type <= '0;
            interboard_block_x  <= '0;
            interboard_block_y  <= '0;
            interboard_card     <= '0;
            interboard_sel_len  <= '0;
        end else begin
            interboard_en  <= 1'b0;
            interboard_rst <= 1'b0;
            frame_err      <= 1'b0;
            if (drain && !req_s) drain <= 1'b0;

            if (timeout) begin
                ack       <= 1'b0;
                beat      <= 2'd0;
                frame_err <= 1'b1;
                state     <= S_WAIT_REQ;
                tcnt      <= '0;
                drain     <= req_s;
            end else begin
                case (state)
                    S_WAIT_REQ: begin
                        if (req_s && !drain) begin
                            sh    <= {sh[FRAME_W-BEAT_W-1:0], ib.ib_data};
                            ack   <= 1'b1;
                            state <= S_WAIT_REL;
                            tcnt  <= '0;
                        end else if (counting) begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    S_WAIT_REL: begin
                        if (!req_s) begin
                            ack   <= 1'b0;
                            beat  <= beat + 2'd1;
                            state <= (beat == 2'd3) ? S_DECODE : S_WAIT_REQ;
                            tcnt  <= '0;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    S_DECODE: begin
                        if (!frame_ok(sh)) begin
                            frame_err <= 1'b1;
                        end else if (fr.msg_type == MSG_RST) begin
                            interboard_rst <= 1'b1;
                        end else begin
                            interboard_en       <= 1'b1;
                            interboard_msg_type <= fr.msg_type;
                            interboard_move_dir <= fr.move_dir;
                            interboard_sel_len  <= fr.sel_len;
                            interboard_block_x  <= fr.block_x;
                            interboard_block_y  <= fr.block_y;
                            interboard_card     <= fr.card;
                        end
                        beat  <= 2'd0;
                        state <= S_WAIT_REQ;
                        tcnt  <= '0;
                    end
                    default: begin
                        state <= S_WAIT_REQ;
                        tcnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_interboard_rx.sv
// Bench for interboard_rx: table of frames through a peer model, scoreboard of expected
// strobes, plus timeout, drain and async-reset sequences.
module tb_interboard_rx;
    import interboard_rx_pkg::*;

    typedef enum int {K_EN = 0, K_RST = 1, K_ERR = 2} kind_t;
    typedef struct {
        kind_t      kind;
        ib_fields_t f;
    } exp_t;
    typedef struct {
        ib_fields_t f;
        int         corrupt;
        kind_t      kind;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    interboard_rx_if ib ();

    logic       en, dir, irst, ferr, busy;
    logic [3:0] msg;
    logic [4:0] bx;
    logic [2:0] by, slen;
    logic [5:0] card;
    ib_fields_t dutFields;

    assign dutFields = {msg, dir, slen, bx, by, card};

    interboard_rx #(.TIMEOUT_CYC(16), .SYNC_STAGES(2)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ib                  (ib),
        .interboard_en       (en),
        .interboard_move_dir (dir),
        .interboard_msg_type (msg),
        .interboard_block_x  (bx),
        .interboard_block_y  (by),
        .interboard_card     (card),
        .interboard_sel_len  (slen),
        .interboard_rst      (irst),
        .frame_err           (ferr),
        .busy                (busy)
    );

    int         cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t       sbQ[$];
    int         errors = 0;
    int         checks = 0;
    int         ackPulses = 0;
    int         errCyc = 0;
    ib_fields_t lastFields = '0;
    vec_t       vecs[7];

    function automatic ib_fields_t mkFields(input logic [3:0] m, input logic d, input logic [2:0] l,
                                            input logic [4:0] x, input logic [2:0] y, input logic [5:0] c);
        ib_fields_t f;
        f = {m, d, l, x, y, c};
        return f;
    endfunction

    function automatic logic [23:0] buildFrame(input ib_fields_t f, input int corrupt);
        logic [23:0] fr;
        fr = {f, ^f, 1'b1};
        if (corrupt == 1) fr[1] = ~fr[1];
        if (corrupt == 2) fr[0] = 1'b0;
        return fr;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic waitAck(input logic val, input int budget);
        int k = 0;
        while (ib.ib_ack !== val && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput("ack_handshake", {31'd0, ib.ib_ack}, {31'd0, val});
    endtask

    task automatic sendBeat(input logic [5:0] d);
        @(negedge clk);
        ib.ib_data = d;
        @(negedge clk);
        ib.ib_req = 1'b1;
        waitAck(1'b1, 30);
        ib.ib_req = 1'b0;
        waitAck(1'b0, 30);
    endtask

    task automatic applyStimulus(input logic [23:0] frame, input int nBeats);
        for (int b = 0; b < nBeats; b++) sendBeat(frame[23-6*b -: 6]);
    endtask

    task automatic pushExp(input kind_t k, input ib_fields_t f);
        exp_t e;
        e.kind = k;
        e.f    = f;
        sbQ.push_back(e);
    endtask

    task automatic waitDrain(input int budget);
        int k = 0;
        while (sbQ.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput("strobe_arrived", sbQ.size(), 0);
        sbQ.delete();
    endtask

    task automatic runMonitor();
        logic  ackPrev = 1'b0;
        kind_t got;
        exp_t  e;
        forever begin
            @(negedge clk);
            if (!rst_n) lastFields = '0;
            if (ib.ib_ack && !ackPrev) ackPulses++;
            ackPrev = ib.ib_ack;
            if (en || irst || ferr) begin
                checkOutput("strobe_exclusive", 32'(en) + 32'(irst) + 32'(ferr), 1);
                got = en ? K_EN : (irst ? K_RST : K_ERR);
                if (ferr) errCyc = cyc;
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_strobe: got kind %0d expected none", got);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("strobe_kind", 32'(got), 32'(e.kind));
                    if (e.kind == K_EN) begin
                        checkOutput("decoded_fields", 32'(dutFields), 32'(e.f));
                        lastFields = e.f;
                    end else begin
                        checkOutput("fields_held", 32'(dutFields), 32'(lastFields));
                    end
                end
            end
        end
    endtask

    task automatic runTest();
        int t0;
        ib_fields_t f;
        ib.ib_req  = 1'b0;
        ib.ib_data = '0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", {ib.ib_ack, en, irst, ferr, busy, 5'd0, dutFields}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        vecs[0] = '{mkFields(MSG_TABLE_DOWN, 1'b0, 3'd0, 5'd5, 3'd2, 6'd13), 0, K_EN};
        vecs[1] = '{mkFields(MSG_TABLE_DOWN, 1'b0, 3'd0, 5'd5, 3'd2, 6'd13), 1, K_ERR};
        vecs[2] = '{mkFields(MSG_RST, 1'b1, 3'd2, 5'd9, 3'd4, 6'd20), 0, K_RST};
        vecs[3] = '{mkFields(MSG_TABLE_SHIFT, 1'b1, 3'd3, 5'd17, 3'd0, 6'd54), 0, K_EN};
        vecs[4] = '{mkFields(MSG_STATE_TURN, 1'b0, 3'd1, 5'd0, 3'd7, 6'd0), 0, K_EN};
        vecs[5] = '{mkFields(MSG_HAND_DOWN, 1'b1, 3'd5, 5'd12, 3'd3, 6'd33), 2, K_ERR};
        vecs[6] = '{mkFields(MSG_STATE_RST_TABLE, 1'b1, 3'd7, 5'd31, 3'd7, 6'd63), 0, K_EN};

        for (int i = 0; i < 7; i++) begin
            ackPulses = 0;
            pushExp(vecs[i].kind, vecs[i].f);
            applyStimulus(buildFrame(vecs[i].f, vecs[i].corrupt), 4);
            waitDrain(10);
            checkOutput("ack_pulses", ackPulses, 4);
        end

        $display("[TB] timeout after two beats");
        pushExp(K_ERR, '0);
        f = mkFields(MSG_HAND_TAKE, 1'b0, 3'd1, 5'd1, 3'd1, 6'd1);
        applyStimulus(buildFrame(f, 0), 2);
        t0 = cyc;
        checkOutput("busy_mid_frame", {31'd0, busy}, 1);
        waitDrain(40);
        checkOutput("timeout_latency", errCyc - t0, 16);
        checkOutput("busy_after_timeout", {31'd0, busy}, 0);
        f = mkFields(MSG_TABLE_TAKE, 1'b1, 3'd2, 5'd8, 3'd6, 6'd40);
        pushExp(K_EN, f);
        applyStimulus(buildFrame(f, 0), 4);
        waitDrain(10);

        $display("[TB] timeout with req held high");
        pushExp(K_ERR, '0);
        @(negedge clk);
        ib.ib_data = 6'h2A;
        @(negedge clk);
        ib.ib_req = 1'b1;
        waitAck(1'b1, 30);
        repeat (30) @(negedge clk);
        checkOutput("held_req_timeout", sbQ.size(), 0);
        repeat (5) @(negedge clk);
        checkOutput("drain_no_recapture", {ib.ib_ack, busy}, 0);
        ib.ib_req = 1'b0;
        sbQ.delete();
        repeat (4) @(negedge clk);
        f = mkFields(MSG_HAND_DOWN, 1'b0, 3'd4, 5'd16, 3'd5, 6'd7);
        pushExp(K_EN, f);
        applyStimulus(buildFrame(f, 0), 4);
        waitDrain(10);

        $display("[TB] async reset mid-beat");
        @(negedge clk);
        ib.ib_data = 6'h15;
        @(negedge clk);
        ib.ib_req = 1'b1;
        waitAck(1'b1, 30);
        #1 rst_n = 1'b0;
        #1 checkOutput("async_reset_ack", {31'd0, ib.ib_ack}, 0);
        @(negedge clk);
        ib.ib_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("fields_after_reset", {ib.ib_ack, busy, 8'd0, dutFields}, 0);
        f = mkFields(MSG_HAND_TAKE, 1'b0, 3'd0, 5'd3, 3'd7, 6'd53);
        pushExp(K_EN, f);
        applyStimulus(buildFrame(f, 0), 4);
        waitDrain(10);

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_empty", sbQ.size(), 0);
    endtask

    initial begin
        fork
            runMonitor();
            runTest();
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
